reg_bus_arbiter: RTL

//  Shares the single cfg register-list port (reg_ce/reg_we/addr/16-bit data) between

---
 rtl/reg_bus_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the cfg register port between NREQ requesters.
// One access in flight; every output is registered; read data captured RD_LAT cycles after the grant.
module reg_bus_arbiter #(
   parameter int NREQ   = 3,
   parameter int AW     = 8,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   ack,
   output logic [DW-1:0]     rdata,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              reg_ce,
   output logic              reg_we,
   output logic [AW-1:0]     reg_addr,
   output logic [DW-1:0]     reg_wdata,
   input  logic [DW-1:0]     reg_rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t          state, state_d;
   logic [PW-1:0]   ptr, ptr_d, pick;
   logic [2:0]      cnt, cnt_d;
   logic [NREQ-1:0] ack_d, gnt_d, pick_oh;
   logic [DW-1:0]   rdata_d, wdata_d, sel_wdata;
   logic [AW-1:0]   addr_d, sel_addr;
   logic            busy_d, ce_d, we_d, sel_we, found;
   int              rr_idx;

   // First requesting index at or after ptr, wrapping past NREQ-1
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      rr_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         rr_idx = int'(ptr) + k;
         if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
         if (!found && req[rr_idx]) begin
            found = 1'b1;
            pick  = PW'(rr_idx);
         end
      end
   end

   always_comb begin
      pick_oh   = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick == PW'(k)) begin
            pick_oh[k] = 1'b1;
            sel_we     = req_we[k];
            sel_addr   = req_addr[k*AW +: AW];
            sel_wdata  = req_wdata[k*DW +: DW];
         end
      end
   end

   // gnt holds the winner one-hot for the whole access, so ack is simply a copy of it.
   // The WAIT counter is loaded with RD_LAT-1 and the capture happens on its last count,
   // which puts the sample at the end of the RD_LAT-th cycle after the IDLE decision.
   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      cnt_d   = cnt;
      ack_d   = '0;
      rdata_d = rdata;
      gnt_d   = gnt;
      busy_d  = busy;
      ce_d    = 1'b0;
      we_d    = reg_we;
      addr_d  = reg_addr;
      wdata_d = reg_wdata;
      unique case (state)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (found) begin
               gnt_d   = pick_oh;
               busy_d  = 1'b1;
               ce_d    = 1'b1;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               ptr_d   = (pick == PW'(NREQ-1)) ? '0 : pick + PW'(1);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (reg_we) begin
               ack_d   = gnt;
               state_d = DONE;
            end else if (RD_LAT == 1) begin
               rdata_d = reg_rdata;
               ack_d   = gnt;
               state_d = DONE;
            end else begin
               cnt_d   = 3'(RD_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 3'd1) begin
               rdata_d = reg_rdata;
               ack_d   = gnt;
               state_d = DONE;
            end else begin
               cnt_d = cnt - 3'd1;
            end
         end
         DONE: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         ack       <= '0;
         rdata     <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         reg_ce    <= 1'b0;
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         cnt       <= cnt_d;
         ack       <= ack_d;
         rdata     <= rdata_d;
         gnt       <= gnt_d;
         busy      <= busy_d;
         reg_ce    <= ce_d;
         reg_we    <= we_d;
         reg_addr  <= addr_d;
         reg_wdata <= wdata_d;
      end
   end

endmodule
